// File: rtl/half_adder_pkg.sv
// Shared defaults for the half_adder leaf primitive.
package half_adder_pkg;

  localparam int unsigned HA_WIDTH_DEFAULT = 1;
  localparam int unsigned HA_CNT_W_DEFAULT = 8;

endpackage : half_adder_pkg

// File: rtl/half_adder_bit.sv
// One lane of the half adder: pure combinational xor/and.
module half_adder_bit (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule : half_adder_bit

// File: rtl/half_adder.sv
// Bitwise half adder with zero-latency sum/carry, registered copies and a
// saturating count of enabled cycles carrying on any lane.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int unsigned WIDTH = HA_WIDTH_DEFAULT,
  parameter int unsigned CNT_W = HA_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic any_carry;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
    half_adder_bit u_bit (
      .a     (A[i]),
      .b     (B[i]),
      .sum   (sum[i]),
      .carry (carry[i])
    );
  end

  // One event per cycle regardless of how many lanes carry.
  assign any_carry = |carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
    end else if (en) begin
      sum_q   <= sum;
      carry_q <= carry;
    end
  end

  // Clear wins over increment; increment sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt <= '0;
    end else if (clr) begin
      carry_cnt <= '0;
    end else if (en && any_carry && (carry_cnt != CNT_MAX)) begin
      carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end

endmodule : half_adder

// File: tb/tb_half_adder.sv
// Self-checking bench for half_adder: truth-table vectors, directed
// multi-cycle sequences and randomized traffic against a lane-arithmetic model.
module tb_half_adder;

  localparam int MAX1 = 3;    // CNT_W=2
  localparam int MAX4 = 255;  // CNT_W=8

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [3:0] a4 = '0, b4 = '0;

  logic [0:0] sum1, carry1, sq1, cq1;
  logic [1:0] cnt1;
  logic [3:0] sum4, carry4, sq4, cq4;
  logic [7:0] cnt4;

  int n_cmp = 0;
  int n_fail = 0;

  // Model state
  logic [3:0] m_sq4, m_cq4;
  logic       m_sq1, m_cq1;
  int         m_cnt1, m_cnt4;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .en(en), .clr(clr),
    .sum(sum1), .carry(carry1), .sum_q(sq1), .carry_q(cq1), .carry_cnt(cnt1)
  );

  half_adder #(.WIDTH(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .en(en), .clr(clr),
    .sum(sum4), .carry(carry4), .sum_q(sq4), .carry_q(cq4), .carry_cnt(cnt4)
  );

  typedef struct {
    logic a;
    logic b;
    logic s;
    logic c;
  } tt_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lane value as a two-bit arithmetic sum: low bit is sum, high bit is carry.
  function automatic logic [3:0] ref_sum(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ((int'(a[i]) + int'(b[i])) % 2) == 1;
    return r;
  endfunction

  function automatic logic [3:0] ref_carry(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ((int'(a[i]) + int'(b[i])) / 2) == 1;
    return r;
  endfunction

  task automatic model_reset();
    m_sq1 = 1'b0; m_cq1 = 1'b0; m_cnt1 = 0;
    m_sq4 = '0;   m_cq4 = '0;   m_cnt4 = 0;
  endtask

  // Advance one clock edge, predicting the registered state from the inputs.
  task automatic step();
    logic [3:0] s1, c1, s4, c4;
    int n1, n4;
    s1 = ref_sum({3'b0, a1}, {3'b0, b1});
    c1 = ref_carry({3'b0, a1}, {3'b0, b1});
    s4 = ref_sum(a4, b4);
    c4 = ref_carry(a4, b4);
    n1 = m_cnt1;
    n4 = m_cnt4;
    if (clr) begin
      n1 = 0; n4 = 0;
    end else if (en) begin
      if (c1 != 0) n1 = (m_cnt1 + 1 > MAX1) ? MAX1 : m_cnt1 + 1;
      if (c4 != 0) n4 = (m_cnt4 + 1 > MAX4) ? MAX4 : m_cnt4 + 1;
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (en) begin
        m_sq1 = s1[0]; m_cq1 = c1[0];
        m_sq4 = s4;    m_cq4 = c4;
      end
      m_cnt1 = n1;
      m_cnt4 = n4;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/sum1"},   32'(sum1),   32'(ref_sum({3'b0, a1}, {3'b0, b1})));
    chk({tag, "/carry1"}, 32'(carry1), 32'(ref_carry({3'b0, a1}, {3'b0, b1})));
    chk({tag, "/sq1"},    32'(sq1),    32'(m_sq1));
    chk({tag, "/cq1"},    32'(cq1),    32'(m_cq1));
    chk({tag, "/cnt1"},   32'(cnt1),   32'(m_cnt1));
    chk({tag, "/sum4"},   32'(sum4),   32'(ref_sum(a4, b4)));
    chk({tag, "/carry4"}, 32'(carry4), 32'(ref_carry(a4, b4)));
    chk({tag, "/sq4"},    32'(sq4),    32'(m_sq4));
    chk({tag, "/cq4"},    32'(cq4),    32'(m_cq4));
    chk({tag, "/cnt4"},   32'(cnt4),   32'(m_cnt4));
  endtask

  initial begin
    tt_vec_t tt[4];
    int exp_cnt[5];
    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tt[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tt[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_cnt = '{1, 2, 3, 3, 3};
    model_reset();

    // Reset state and truth table while held in reset
    #1;
    chk("rst/sq1", 32'(sq1), 32'd0);
    chk("rst/cq1", 32'(cq1), 32'd0);
    chk("rst/cnt1", 32'(cnt1), 32'd0);
    chk("rst/cnt4", 32'(cnt4), 32'd0);
    for (int i = 0; i < 4; i++) begin
      a1 = tt[i].a;
      b1 = tt[i].b;
      #1;
      chk($sformatf("tt%0d/sum", i), 32'(sum1), 32'(tt[i].s));
      chk($sformatf("tt%0d/carry", i), 32'(carry1), 32'(tt[i].c));
      #9;
    end

    // Release between edges
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'b0; b1 = 1'b0;
    step();
    check_all("idle");

    // Registered path: load 1+1, then hold with en=0
    a1 = 1'b1; b1 = 1'b1; en = 1'b1;
    step();
    chk("reg/sq1", 32'(sq1), 32'd0);
    chk("reg/cq1", 32'(cq1), 32'd1);
    chk("reg/cnt1", 32'(cnt1), 32'd1);
    a1 = 1'b0; b1 = 1'b1; en = 1'b0;
    step();
    chk("hold/sq1", 32'(sq1), 32'd0);
    chk("hold/cq1", 32'(cq1), 32'd1);
    chk("hold/cnt1", 32'(cnt1), 32'd1);
    check_all("hold");

    // Saturating counter on the 2-bit instance
    clr = 1'b1;
    step();
    chk("clr/cnt1", 32'(cnt1), 32'd0);
    clr = 1'b0; en = 1'b1; a1 = 1'b1; b1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("sat%0d/cnt1", i), 32'(cnt1), 32'(exp_cnt[i]));
    end
    clr = 1'b1;
    step();
    chk("clr_carry/cnt1", 32'(cnt1), 32'd0);
    check_all("clr_carry");
    clr = 1'b0;

    // Multi-lane: one event per cycle, not per lane
    a4 = 4'b1100; b4 = 4'b1010;
    #1;
    chk("ml/sum4", 32'(sum4), 32'h6);
    chk("ml/carry4", 32'(carry4), 32'h8);
    step();
    chk("ml/cnt4", 32'(cnt4), 32'(m_cnt4));
    a4 = 4'b1111; b4 = 4'b1111;
    step();
    check_all("ml_all");

    // Async reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst/sq1", 32'(sq1), 32'd0);
    chk("arst/cq4", 32'(cq4), 32'd0);
    chk("arst/cnt1", 32'(cnt1), 32'd0);
    chk("arst/cnt4", 32'(cnt4), 32'd0);
    a4 = 4'b0110; b4 = 4'b0011;
    #1;
    chk("arst/sum4", 32'(sum4), 32'h5);
    chk("arst/carry4", 32'(carry4), 32'h2);
    step();
    check_all("arst_edge");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      a1  = 1'($urandom);
      b1  = 1'($urandom);
      a4  = 4'($urandom);
      b4  = 4'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      #1;
      chk("rnd/sum4", 32'(sum4), 32'(ref_sum(a4, b4)));
      step();
      check_all("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_half_adder
